tx: RTL and testbench

PICC→PCD transmitter for ISO/IEC 14443A at 106 kbit/s, the counterpart of `rx`. It accepts a frame as a stream of bytes from the frame logic and appends odd parity to every full byte. It Manchester-encodes the frame with SOC and EOC, using the fc/16 subcarrier, and drives the load-modulation control `lm_out`. It runs on the carrier-derived clock, so fc is 13.56 MHz and one bit is 128 `clk`.

---
 rtl/ISO14443A_pkg.sv | 38 +++
 rtl/tx_manchester_subcarrier_encoder.sv | 58 +++++
 rtl/tx.sv | 214 +++++++++++++++++++++
 tb/tb_tx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ISO14443A_pkg.sv
// ----------------------------------------------------------------------------
// ISO14443A_pkg
// Shared timing constants and types for the ISO/IEC 14443A 106 kbit/s PICC
// datapath. All timing is expressed in carrier clocks (fc = 13.56 MHz).
//
// Contents:
//   PICC_BIT_PERIOD_CLKS      one bit on air = 128 fc
//   PICC_HALF_BIT_CLKS        one Manchester half-bit = 64 fc
//   PICC_SUBCARRIER_HALF_CLKS half a subcarrier period (fc/16) = 8 fc
//   TxState                   transmitter FSM states
//   odd_parity()              parity bit that makes the 9-bit group odd
// ----------------------------------------------------------------------------
package ISO14443A_pkg;

  localparam int PICC_BIT_PERIOD_CLKS      = 128;
  localparam int PICC_HALF_BIT_CLKS        = PICC_BIT_PERIOD_CLKS / 2;
  localparam int PICC_SUBCARRIER_HALF_CLKS = 8;

  // Width of the in-bit clock counter and the counter bit that toggles the
  // subcarrier (bit 3 for an 8-clock half period).
  localparam int PICC_BIT_CNT_W    = $clog2(PICC_BIT_PERIOD_CLKS);
  localparam int PICC_SC_TOGGLE_IX = $clog2(PICC_SUBCARRIER_HALF_CLKS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SOC    = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    EOC    = 3'd4
  } TxState;

  // Odd parity: the parity bit is chosen so that data plus parity holds an
  // odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/tx_manchester_subcarrier_encoder.sv
// ----------------------------------------------------------------------------
// manchester_subcarrier_encoder
// Turns one logical bit per 128-clock bit period into the load-modulation
// pattern of ISO 14443A Type A PICC->PCD signalling: Manchester coding with
// the modulated half-bit filled by the fc/16 subcarrier.
//
// Ports:
//   clk         in   carrier clock
//   rst         in   synchronous, active-high reset
//   bit_value   in   logical value of the bit currently on air
//   bit_active  in   a bit period is in progress (low holds the counter at 0)
//   bit_is_eoc  in   current bit period is EOC: no modulation at all
//   lm_out      out  load-modulation enable, 1 = modulate
//   bit_end     out  strobe on the last clock (c = 127) of a bit period
// ----------------------------------------------------------------------------
module manchester_subcarrier_encoder
  import ISO14443A_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bit_value,
  input  logic bit_active,
  input  logic bit_is_eoc,
  output logic lm_out,
  output logic bit_end
);

  localparam logic [PICC_BIT_CNT_W-1:0] LAST_CLK = PICC_BIT_CNT_W'(PICC_BIT_PERIOD_CLKS - 1);

  // In-bit clock counter c. It wraps naturally from 127 to 0, so consecutive
  // bit periods follow each other without any reload logic. While no bit is
  // active it sits at 0, so the first clock of SOC is always c = 0.
  logic [PICC_BIT_CNT_W-1:0] r_count;

  logic w_first_half;
  logic w_modulated_half;

  always_ff @(posedge clk) begin
    if (rst || !bit_active) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // MSB of c is 0 during c = 0..63.
  assign w_first_half = ~r_count[PICC_BIT_CNT_W-1];

  // Logic 1 modulates the first half, logic 0 the second half.
  assign w_modulated_half = bit_active && !bit_is_eoc && (bit_value == w_first_half);

  // Subcarrier starts high at the beginning of each modulated half: 8 clocks
  // high, 8 clocks low, four subcarrier cycles per half-bit.
  assign lm_out  = w_modulated_half && ~r_count[PICC_SC_TOGGLE_IX];

  assign bit_end = bit_active && (r_count == LAST_CLK);

endmodule

// File: rtl/tx.sv
// ----------------------------------------------------------------------------
// tx
// PICC->PCD transmitter for ISO/IEC 14443A at 106 kbit/s. Takes a frame as a
// byte stream, appends odd parity to every full byte, frames it with SOC and
// EOC and drives the load-modulation control through the Manchester /
// subcarrier encoder. Runs on the carrier clock: one bit = 128 clk.
//
// Ports:
//   clk           in   carrier clock, fc
//   rst           in   synchronous, active-high reset
//   in_data[7:0]  in   byte to send, LSB first on air
//   in_data_bits  in   0 = full byte with parity, 1..7 = that many LSBs, no
//                      parity (partial byte always ends the frame)
//   in_last       in   final byte of the frame
//   in_valid      in   byte present
//   in_ready      out  hold register empty
//   lm_out        out  load-modulation enable, 1 = modulate
//   busy          out  frame in progress (SOC through EOC)
//   underrun      out  one-cycle pulse on the first EOC cycle when the next
//                      byte was needed at the end of a parity bit but absent
//   dbg_state     out  current FSM state (TxState encoding)
//
// Handshake: a byte transfers on every rising clk edge where in_valid and
// in_ready are both high. in_valid may be raised at any time and the byte
// fields must stay stable while in_valid is high and in_ready is low;
// in_ready never depends on in_valid.
// ----------------------------------------------------------------------------
module tx
  import ISO14443A_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic [2:0] in_data_bits,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       lm_out,
  output logic       busy,
  output logic       underrun,
  output logic [2:0] dbg_state
);

  // FSM
  TxState r_state;
  TxState w_next_state;

  // One-deep hold register
  logic       r_hold_full;
  logic [7:0] r_hold_data;
  logic [2:0] r_hold_bits;
  logic       r_hold_last;

  // Byte on air
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;     // data bits already sent of the current byte
  logic [2:0] r_bit_cnt_end; // index of the final data bit (7 for a full byte)
  logic       r_full_byte;
  logic       r_byte_last;
  logic       r_parity;

  logic r_underrun;

  // FSM decode outputs
  logic w_accept;
  logic w_load;
  logic w_underrun_set;
  logic w_bit_value;
  logic w_bit_active;
  logic w_bit_is_eoc;
  logic w_bit_end;

  assign in_ready = !r_hold_full && !rst;
  assign w_accept = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Hold register. A load into the shift register and a new accept never
  // coincide: loading requires the hold to be full, which keeps in_ready low.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
      r_hold_bits <= '0;
      r_hold_last <= 1'b0;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_data <= in_data;
      r_hold_bits <= in_data_bits;
      r_hold_last <= in_last;
    end
  end

  // --------------------------------------------------------------------------
  // Shift register, bit counter and parity of the byte on air.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_bit_cnt_end <= '0;
      r_full_byte   <= 1'b0;
      r_byte_last   <= 1'b0;
      r_parity      <= 1'b0;
    end else if (w_load) begin
      r_shift       <= r_hold_data;
      r_bit_cnt     <= '0;
      r_bit_cnt_end <= (r_hold_bits == 3'd0) ? 3'd7 : (r_hold_bits - 3'd1);
      r_full_byte   <= (r_hold_bits == 3'd0);
      // A partial byte cannot be followed by anything, so it ends the frame
      // even when in_last was not given with it.
      r_byte_last   <= r_hold_last || (r_hold_bits != 3'd0);
      r_parity      <= odd_parity(r_hold_data);
    end else if ((r_state == DATA) && w_bit_end) begin
      r_shift   <= {1'b0, r_shift[7:1]};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register and underrun pulse register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_underrun <= w_underrun_set;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and per-state bit selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state   = r_state;
    w_load         = 1'b0;
    w_underrun_set = 1'b0;
    w_bit_value    = 1'b0;
    w_bit_active   = 1'b1;
    w_bit_is_eoc   = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_bit_active = 1'b0;
        if (r_hold_full) begin
          w_next_state = SOC;
        end
      end

      SOC: begin
        w_bit_value = 1'b1;
        if (w_bit_end) begin
          w_load       = 1'b1;
          w_next_state = DATA;
        end
      end

      DATA: begin
        w_bit_value = r_shift[0];
        if (w_bit_end && (r_bit_cnt == r_bit_cnt_end)) begin
          w_next_state = r_full_byte ? PARITY : EOC;
        end
      end

      PARITY: begin
        w_bit_value = r_parity;
        if (w_bit_end) begin
          if (r_byte_last) begin
            w_next_state = EOC;
          end else if (r_hold_full) begin
            w_load       = 1'b1;
            w_next_state = DATA;
          end else begin
            // The frame was meant to continue but the next byte is missing:
            // close it with EOC and flag the underrun.
            w_underrun_set = 1'b1;
            w_next_state   = EOC;
          end
        end
      end

      EOC: begin
        w_bit_is_eoc = 1'b1;
        if (w_bit_end) begin
          w_next_state = IDLE;
        end
      end

      default: begin
        w_bit_active = 1'b0;
        w_next_state = IDLE;
      end
    endcase
  end

  manchester_subcarrier_encoder u_encoder (
    .clk        (clk),
    .rst        (rst),
    .bit_value  (w_bit_value),
    .bit_active (w_bit_active),
    .bit_is_eoc (w_bit_is_eoc),
    .lm_out     (lm_out),
    .bit_end    (w_bit_end)
  );

  assign busy      = (r_state != IDLE);
  assign underrun  = r_underrun;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tx.sv
// ----------------------------------------------------------------------------
// tb_tx
// Self-checking bench for tx. A frame-level model expands each frame into the
// bit sequence on air (SOC, data LSB first, odd parity, EOC) and each bit into
// its 128 expected {busy, lm_out, underrun} samples; one compare process
// checks the DUT against that expected queue on every cycle. Directed frames
// add literal checks of frame lengths, start latency and underrun timing.
// ----------------------------------------------------------------------------
module tb_tx;
  import ISO14443A_pkg::*;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic [2:0] in_data_bits = '0;
  logic       in_last = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       lm_out;
  logic       busy;
  logic       underrun;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tx dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_data_bits (in_data_bits),
    .in_last      (in_last),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .lm_out       (lm_out),
    .busy         (busy),
    .underrun     (underrun),
    .dbg_state    (dbg_state)
  );

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected samples {busy, lm_out, underrun}, one per clock cycle.
  logic [2:0] exp_q[$];
  logic [2:0] cmp_e;
  logic       cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      if (exp_q.size() > 0) cmp_e = exp_q.pop_front();
      else                  cmp_e = 3'b000;
      check("busy",     busy,     cmp_e[2]);
      check("lm_out",   lm_out,   cmp_e[1]);
      check("underrun", underrun, cmp_e[0]);
    end
  end

  // Frame monitor: busy run length, busy start cycle, underrun pulses.
  int busy_run = 0, last_busy_len = 0, rise_cyc = 0, und_cyc = 0, und_count = 0;

  always @(negedge clk) begin
    if (busy) begin
      if (busy_run == 0) rise_cyc = cyc;
      busy_run++;
    end else if (busy_run > 0) begin
      last_busy_len = busy_run;
      busy_run      = 0;
    end
    if (underrun) begin
      und_count++;
      und_cyc = cyc;
    end
  end

  // --------------------------------------------------------------------------
  // Frame model
  // --------------------------------------------------------------------------
  logic [7:0] fr_data[16];
  logic [2:0] fr_bits[16];
  logic       fr_last[16];
  int         fr_n;
  int         acc_cyc;

  // One bit period: logic 1 modulates the first 64 clocks, logic 0 the last
  // 64; inside a modulated half the subcarrier is high for clocks 0-7 of every
  // 16-clock period. EOC carries no modulation.
  function automatic void push_bit(input logic v, input logic eoc, input logic und);
    for (int c = 0; c < PICC_BIT_PERIOD_CLKS; c++) begin
      logic mod_half;
      logic lm;
      mod_half = v ? (c < 64) : (c >= 64);
      lm       = !eoc && mod_half && ((c / 8) % 2 == 0);
      exp_q.push_back({1'b1, lm, und && (c == 0)});
    end
  endfunction

  function automatic void model_frame();
    logic done;
    logic und;
    done = 1'b0;
    und  = 1'b0;
    exp_q.push_back(3'b000);        // the IDLE cycle between accept and SOC
    push_bit(1'b1, 1'b0, 1'b0);     // SOC
    for (int i = 0; i < fr_n; i++) begin
      if (!done) begin
        int nb;
        int ones;
        nb   = (fr_bits[i] == 3'd0) ? 8 : int'(fr_bits[i]);
        ones = 0;
        for (int j = 0; j < nb; j++) begin
          push_bit(fr_data[i][j], 1'b0, 1'b0);
          ones += int'(fr_data[i][j]);
        end
        if (fr_bits[i] == 3'd0) push_bit((ones % 2) == 0, 1'b0, 1'b0);
        if (fr_last[i] || fr_bits[i] != 3'd0 || i == fr_n - 1) begin
          done = 1'b1;
          und  = (fr_bits[i] == 3'd0) && !fr_last[i];
        end
      end
    end
    push_bit(1'b0, 1'b1, und);      // EOC
  endfunction

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic send_frame();
    for (int i = 0; i < fr_n; i++) begin
      int waited;
      waited = 0;
      @(negedge clk);
      in_data      = fr_data[i];
      in_data_bits = fr_bits[i];
      in_last      = fr_last[i];
      in_valid     = 1'b1;
      #1;
      while (!in_ready && waited < 2000) begin
        @(negedge clk);
        #1;
        waited++;
      end
      if (!in_ready) begin
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      if (i == 0) begin
        acc_cyc = cyc;
        model_frame();
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int w;
    w = 0;
    while ((exp_q.size() > 0 || busy) && w < 20000) begin
      @(negedge clk);
      #1;
      w++;
    end
    check({name, "_done"}, int'(exp_q.size() == 0 && !busy), 1);
  endtask

  task automatic set1(input logic [7:0] d, input logic [2:0] b, input logic l);
    fr_n       = 1;
    fr_data[0] = d;
    fr_bits[0] = b;
    fr_last[0] = l;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int und_before;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy",     busy,     0);
    check("rst_lm_out",   lm_out,   0);
    check("rst_underrun", underrun, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 1);
    cmp_en = 1'b1;

    // 0x00 full, last: SOC + 8 zeros + parity 1 + EOC = 11 bits
    set1(8'h00, 3'd0, 1'b1);
    send_frame();
    check("ready_low_hold_full", in_ready, 0);
    wait_done("f00");
    check("f00_busy_len", last_busy_len, 11 * 128);
    check("f00_soc_latency", rise_cyc - acc_cyc, 2);
    check("ready_idle", in_ready, 1);

    // 0x26, 7 bits: SOC + 7 bits + EOC = 9 bits
    set1(8'h26, 3'd7, 1'b1);
    send_frame();
    wait_done("f26");
    check("f26_busy_len", last_busy_len, 9 * 128);

    // 0xA5 then 0x3C (last), back to back: 2 + 18 = 20 bits
    fr_n = 2;
    fr_data[0] = 8'hA5; fr_bits[0] = 3'd0; fr_last[0] = 1'b0;
    fr_data[1] = 8'h3C; fr_bits[1] = 3'd0; fr_last[1] = 1'b1;
    send_frame();
    wait_done("fa5");
    check("fa5_busy_len", last_busy_len, 20 * 128);

    // 0x12 without last and nothing after it: underrun at EOC start
    und_before = und_count;
    set1(8'h12, 3'd0, 1'b0);
    send_frame();
    wait_done("f12");
    check("f12_busy_len", last_busy_len, 11 * 128);
    check("f12_underrun_count", und_count - und_before, 1);
    check("f12_underrun_offset", und_cyc - rise_cyc, 10 * 128);

    // Reset during data bit 4 of the first byte
    set1(8'h5A, 3'd0, 1'b1);
    send_frame();
    while (cyc < acc_cyc + 2 + 5 * 128 + 20) @(negedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    check("midrst_busy",     busy,     0);
    check("midrst_lm_out",   lm_out,   0);
    check("midrst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("midrst_ready_after", in_ready, 1);

    // Fresh 0xFF frame after the reset
    set1(8'hFF, 3'd0, 1'b1);
    send_frame();
    wait_done("fff");
    check("fff_busy_len", last_busy_len, 11 * 128);

    // Byte offered in the final EOC cycle: one IDLE cycle, then its SOC
    set1(8'hC3, 3'd0, 1'b1);
    send_frame();
    begin
      int w;
      w = 0;
      while (exp_q.size() != 1 && w < 5000) begin
        @(negedge clk);
        #1;
        w++;
      end
      check("eoc_edge_reached", int'(exp_q.size() == 1), 1);
    end
    set1(8'h81, 3'd3, 1'b1);
    send_frame();
    check("eoc_edge_accept_cycle", acc_cyc - rise_cyc, 11 * 128 - 1);
    wait_done("f81");
    check("f81_busy_len", last_busy_len, 5 * 128);
    check("f81_soc_latency", rise_cyc - acc_cyc, 2);

    // Random frames, 1-4 bytes, last byte full or partial
    for (int f = 0; f < 3; f++) begin
      fr_n = int'($urandom_range(1, 4));
      for (int i = 0; i < fr_n; i++) begin
        fr_data[i] = 8'($urandom_range(0, 255));
        fr_bits[i] = 3'd0;
        fr_last[i] = (i == fr_n - 1);
      end
      fr_bits[fr_n - 1] = 3'($urandom_range(0, 7));
      send_frame();
      wait_done("rnd");
      check("rnd_busy_len", last_busy_len,
            (fr_bits[fr_n - 1] == 3'd0) ? (2 + 9 * fr_n) * 128
                                        : (2 + 9 * (fr_n - 1) + int'(fr_bits[fr_n - 1])) * 128);
    end

    repeat (4) @(negedge clk);
    check("underrun_total", und_count, 1);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end

endmodule
